// File: rtl/sys_array_pkg.sv
// Shared types and constants for the 2x2 systolic array feeder.
package sys_array_pkg;
    localparam int ARR_N     = 2;
    localparam int NUM_WAVES = 2 * ARR_N - 1;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        WAIT
    } state_e;
endpackage

// File: rtl/sys_feed_wave_sel.sv
// Wavefront mux: row i carries A[i][k-i], column j carries B[k-j][j] on wave k.
module sys_feed_wave_sel
    import sys_array_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int WW     = 2
) (
    input  logic [WW-1:0]                          wave,
    input  logic [ARR_N-1:0][ARR_N-1:0][DATA_W-1:0] a,
    input  logic [ARR_N-1:0][ARR_N-1:0][DATA_W-1:0] b,
    output logic [ARR_N-1:0][DATA_W-1:0]            row,
    output logic [ARR_N-1:0][DATA_W-1:0]            col
);
    always_comb begin
        for (int i = 0; i < ARR_N; i++) begin
            row[i] = DATA_W'(FP_ZERO);
            col[i] = DATA_W'(FP_ZERO);
            for (int k = 0; k < ARR_N; k++) begin
                if (int'(wave) == i + k) begin
                    row[i] = a[i][k];
                    col[i] = b[k][i];
                end
            end
        end
    end
endmodule

// File: rtl/sys_array_feeder.sv
// Feeds captured 2x2 A/B operands to the systolic array as skewed wavefronts,
// then waits for the array's done pulse or a timeout before the next accept.
module sys_array_feeder
    import sys_array_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int STEP_CYCLES = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a00,
    input  logic [DATA_W-1:0] in_a01,
    input  logic [DATA_W-1:0] in_a10,
    input  logic [DATA_W-1:0] in_a11,
    input  logic [DATA_W-1:0] in_b00,
    input  logic [DATA_W-1:0] in_b01,
    input  logic [DATA_W-1:0] in_b10,
    input  logic [DATA_W-1:0] in_b11,
    input  logic              array_done,
    output logic              load_in,
    output logic [DATA_W-1:0] row_in_row0,
    output logic [DATA_W-1:0] row_in_row1,
    output logic [DATA_W-1:0] col_in_col0,
    output logic [DATA_W-1:0] col_in_col1,
    output logic              busy,
    output logic              timeout_err
);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WW = $clog2(NUM_WAVES);

    typedef logic [ARR_N-1:0][ARR_N-1:0][DATA_W-1:0] mat_t;
    typedef logic [ARR_N-1:0][DATA_W-1:0]            vec_t;

    state_e          state_q, state_d;
    logic [SW-1:0]   step_q, step_d;
    logic [WW-1:0]   wave_q, wave_d;
    logic [TW-1:0]   wait_q, wait_d;
    mat_t            a_q, a_d, b_q, b_d;
    logic            in_ready_q, in_ready_d;
    logic            busy_q, busy_d;
    logic            tmo_q, tmo_d;
    logic            load_q, load_d;
    vec_t            row_q, row_d, col_q, col_d;
    vec_t            sel_row, sel_col;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        wave_d  = wave_q;
        wait_d  = wait_q;
        a_d     = a_q;
        b_d     = b_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = FEED;
                    a_d     = {in_a11, in_a10, in_a01, in_a00};
                    b_d     = {in_b11, in_b10, in_b01, in_b00};
                    tmo_d   = 1'b0;
                    wave_d  = '0;
                    step_d  = '0;
                end
            end
            FEED: begin
                if (step_q != SW'(STEP_CYCLES - 1)) begin
                    step_d = step_q + SW'(1);
                end else if (wave_q != WW'(NUM_WAVES - 1)) begin
                    wave_d = wave_q + WW'(1);
                    step_d = '0;
                end else begin
                    state_d = WAIT;
                    wait_d  = '0;
                end
            end
            WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (array_done) begin
                    state_d = IDLE;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mux runs on next-state values so the registered streams line up with load_in.
    sys_feed_wave_sel #(.DATA_W(DATA_W), .WW(WW)) u_sel (
        .wave (wave_d),
        .a    (a_d),
        .b    (b_d),
        .row  (sel_row),
        .col  (sel_col)
    );

    always_comb begin
        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
        load_d     = (state_d == FEED) && (step_d == '0);
        row_d      = (state_d == FEED) ? sel_row : '0;
        col_d      = (state_d == FEED) ? sel_col : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            step_q     <= '0;
            wave_q     <= '0;
            wait_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            load_q     <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            wave_q     <= wave_d;
            wait_q     <= wait_d;
            a_q        <= a_d;
            b_q        <= b_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            load_q     <= load_d;
            row_q      <= row_d;
            col_q      <= col_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;
    assign load_in     = load_q;
    assign row_in_row0 = row_q[0];
    assign row_in_row1 = row_q[1];
    assign col_in_col0 = col_q[0];
    assign col_in_col1 = col_q[1];
endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench: two feeders (STEP_CYCLES=1 and 4, TIMEOUT=8) share operands.
module tb_sys_array_feeder;
    import sys_array_pkg::*;

    typedef struct packed {
        fp32_t r0;
        fp32_t r1;
        fp32_t c0;
        fp32_t c1;
    } wave_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    fp32_t a00, a01, a10, a11, b00, b01, b10, b11;
    logic  va, vb, da, db;

    logic  a_ready, a_load, a_busy, a_tmo;
    fp32_t a_r0, a_r1, a_c0, a_c1;
    logic  b_ready, b_load, b_busy, b_tmo;
    fp32_t b_r0, b_r1, b_c0, b_c1;

    wave_t exp_tbl [2][3];
    wave_t qa[$];
    wave_t qb[$];
    wave_t ea, eb;
    int    vectors = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    sys_array_feeder #(.DATA_W(32), .STEP_CYCLES(1), .TIMEOUT(8)) u_a (
        .clk(clk), .rst(rst), .in_valid(va), .in_ready(a_ready),
        .in_a00(a00), .in_a01(a01), .in_a10(a10), .in_a11(a11),
        .in_b00(b00), .in_b01(b01), .in_b10(b10), .in_b11(b11),
        .array_done(da), .load_in(a_load),
        .row_in_row0(a_r0), .row_in_row1(a_r1),
        .col_in_col0(a_c0), .col_in_col1(a_c1),
        .busy(a_busy), .timeout_err(a_tmo)
    );

    sys_array_feeder #(.DATA_W(32), .STEP_CYCLES(4), .TIMEOUT(8)) u_b (
        .clk(clk), .rst(rst), .in_valid(vb), .in_ready(b_ready),
        .in_a00(a00), .in_a01(a01), .in_a10(a10), .in_a11(a11),
        .in_b00(b00), .in_b01(b01), .in_b10(b10), .in_b11(b11),
        .array_done(db), .load_in(b_load),
        .row_in_row0(b_r0), .row_in_row1(b_r1),
        .col_in_col0(b_c0), .col_in_col1(b_c1),
        .busy(b_busy), .timeout_err(b_tmo)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int s);
        if (s == 0) begin
            a00 = 32'h3F800000; a01 = 32'h40000000; a10 = 32'h40400000; a11 = 32'h40800000;
            b00 = 32'h40A00000; b01 = 32'h40C00000; b10 = 32'h40E00000; b11 = 32'h41000000;
        end else begin
            a00 = 32'h7FC00001; a01 = 32'h80000000; a10 = 32'h7F800000; a11 = 32'hFF800000;
            b00 = 32'h00000001; b01 = 32'h80000001; b10 = 32'h7F7FFFFF; b11 = 32'hC0490FDB;
        end
    endtask

    task automatic push(input int d, input int s);
        for (int w = 0; w < 3; w++) begin
            if (d == 0) qa.push_back(exp_tbl[s][w]);
            else        qb.push_back(exp_tbl[s][w]);
        end
    endtask

    // Monitor: every load_in strobe must match the next expected wavefront.
    always @(negedge clk) begin
        if (a_load) begin
            if (qa.size() == 0) begin
                chkb("a_unexpected_load", a_load, 1'b0);
            end else begin
                ea = qa.pop_front();
                chk("a_row0", a_r0, ea.r0);
                chk("a_row1", a_r1, ea.r1);
                chk("a_col0", a_c0, ea.c0);
                chk("a_col1", a_c1, ea.c1);
            end
        end
        if (b_load) begin
            if (qb.size() == 0) begin
                chkb("b_unexpected_load", b_load, 1'b0);
            end else begin
                eb = qb.pop_front();
                chk("b_row0", b_r0, eb.r0);
                chk("b_row1", b_r1, eb.r1);
                chk("b_col0", b_c0, eb.c0);
                chk("b_col1", b_c1, eb.c1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_tbl[0][0] = {32'h3F800000, 32'h00000000, 32'h40A00000, 32'h00000000};
        exp_tbl[0][1] = {32'h40000000, 32'h40400000, 32'h40E00000, 32'h40C00000};
        exp_tbl[0][2] = {32'h00000000, 32'h40800000, 32'h00000000, 32'h41000000};
        exp_tbl[1][0] = {32'h7FC00001, 32'h00000000, 32'h00000001, 32'h00000000};
        exp_tbl[1][1] = {32'h80000000, 32'h7F800000, 32'h7F7FFFFF, 32'h80000001};
        exp_tbl[1][2] = {32'h00000000, 32'hFF800000, 32'h00000000, 32'hC0490FDB};
        va = 0; vb = 0; da = 0; db = 0;
        set_ops(0);

        // reset state
        step(); step();
        chkb("rst_a_ready", a_ready, 1'b0);
        chkb("rst_b_ready", b_ready, 1'b0);
        chkb("rst_b_busy", b_busy, 1'b0);
        chkb("rst_b_load", b_load, 1'b0);
        chkb("rst_b_tmo", b_tmo, 1'b0);
        chk("rst_b_row0", b_r0, 32'h0);
        rst = 0;
        step();
        chkb("rel_a_ready", a_ready, 1'b1);
        chkb("rel_b_ready", b_ready, 1'b1);

        // STEP_CYCLES=1: three back-to-back load_in cycles, then done
        va = 1; push(0, 0);
        step();
        va = 0;
        chkb("a_load_c1", a_load, 1'b1);
        chkb("a_busy_c1", a_busy, 1'b1);
        chkb("a_ready_c1", a_ready, 1'b0);
        step(); chkb("a_load_c2", a_load, 1'b1);
        step(); chkb("a_load_c3", a_load, 1'b1);
        step();
        chkb("a_load_wait", a_load, 1'b0);
        chkb("a_busy_wait", a_busy, 1'b1);
        chk("a_row1_wait", a_r1, 32'h0);
        da = 1; step(); da = 0;
        chkb("a_ready_done", a_ready, 1'b1);
        chkb("a_busy_done", a_busy, 1'b0);
        chkb("a_tmo_done", a_tmo, 1'b0);

        // STEP_CYCLES=4 pacing, special FP values, done ignored in FEED
        set_ops(1); vb = 1; push(1, 1);
        step();
        vb = 0;
        set_ops(0);
        for (int c = 1; c <= 12; c++) begin
            chkb("b_load_pace", b_load, (c % 4) == 1);
            chkb("b_busy_feed", b_busy, 1'b1);
            chk("b_row1_hold", b_r1, exp_tbl[1][(c - 1) / 4].r1);
            chk("b_col0_hold", b_c0, exp_tbl[1][(c - 1) / 4].c0);
            db = (c == 3);
            step();
        end
        db = 0;
        chkb("b_load_wait", b_load, 1'b0);
        chkb("b_busy_wait", b_busy, 1'b1);
        chkb("b_ready_wait", b_ready, 1'b0);
        chk("b_row0_wait", b_r0, 32'h0);
        chk("b_col1_wait", b_c1, 32'h0);
        repeat (4) step();
        db = 1; step(); db = 0;
        chkb("b_ready_done", b_ready, 1'b1);
        chkb("b_busy_done", b_busy, 1'b0);
        chkb("b_tmo_done", b_tmo, 1'b0);

        // timeout after 8 WAIT cycles
        vb = 1; push(1, 0);
        step();
        vb = 0;
        set_ops(1);
        repeat (12) step();
        for (int c = 13; c <= 20; c++) begin
            chkb("b_busy_tmo_wait", b_busy, 1'b1);
            step();
        end
        chkb("b_ready_tmo", b_ready, 1'b1);
        chkb("b_busy_tmo", b_busy, 1'b0);
        chkb("b_tmo_set", b_tmo, 1'b1);
        step();
        chkb("b_tmo_sticky", b_tmo, 1'b1);

        // next accept clears timeout_err; done on final timeout cycle wins
        vb = 1; push(1, 1);
        step();
        vb = 0;
        chkb("b_tmo_cleared", b_tmo, 1'b0);
        repeat (19) step();
        chkb("b_busy_last_wait", b_busy, 1'b1);
        db = 1; step(); db = 0;
        chkb("b_ready_coinc", b_ready, 1'b1);
        chkb("b_tmo_coinc", b_tmo, 1'b0);

        // async reset during wave 1
        set_ops(0); vb = 1; push(1, 0);
        step();
        vb = 0;
        repeat (5) step();
        #2 rst = 1;
        #1;
        chk("ar_row0", b_r0, 32'h0);
        chk("ar_row1", b_r1, 32'h0);
        chk("ar_col0", b_c0, 32'h0);
        chk("ar_col1", b_c1, 32'h0);
        chkb("ar_load", b_load, 1'b0);
        chkb("ar_busy", b_busy, 1'b0);
        chkb("ar_ready", b_ready, 1'b0);
        qb.delete();
        step();
        rst = 0;
        step();
        chkb("ar_ready_rel", b_ready, 1'b1);
        for (int c = 0; c < 10; c++) begin
            chkb("ar_no_load", b_load, 1'b0);
            step();
        end

        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
